// File: rtl/polyphase_mac.sv
// Pipelined frame-based signed multiply-accumulate: one rounded, shifted,
// saturated dot product per frame, delivered through a valid/ready output.
module polyphase_mac #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int COEFF_WIDTH  = 16,
  parameter int ACC_WIDTH    = 40,
  parameter int TAPS         = 31,
  parameter int SHIFT        = 15,
  parameter int ROUND        = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           valid_in,
  input  logic                           last_in,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
  input  logic signed [COEFF_WIDTH-1:0]  coeff_in,
  output logic                           in_ready,
  output logic                           valid_out,
  input  logic                           out_ready,
  output logic signed [SAMPLE_WIDTH-1:0] data_out,
  output logic                           sat_out,
  output logic                           err_out
);

  localparam int PROD_W = SAMPLE_WIDTH + COEFF_WIDTH;
  localparam int CNT_W  = (TAPS > 1) ? $clog2(TAPS) : 1;

  localparam logic signed [ACC_WIDTH:0] RND =
    (ROUND != 0 && SHIFT > 0) ? ((ACC_WIDTH+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [ACC_WIDTH:0] MAXV =
    {{(ACC_WIDTH-SAMPLE_WIDTH+2){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MINV =
    {{(ACC_WIDTH-SAMPLE_WIDTH+2){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, ACCUM} state_t;

  function automatic logic signed [ACC_WIDTH:0] round_shift(input logic signed [ACC_WIDTH-1:0] a);
    logic signed [ACC_WIDTH:0] t;
    t = (ACC_WIDTH+1)'(a) + RND;
    return t >>> SHIFT;
  endfunction

  // Returns {clipped, value}.
  function automatic logic [SAMPLE_WIDTH:0] saturate(input logic signed [ACC_WIDTH:0] v);
    if (v > MAXV)
      return {1'b1, MAXV[SAMPLE_WIDTH-1:0]};
    else if (v < MINV)
      return {1'b1, MINV[SAMPLE_WIDTH-1:0]};
    else
      return {1'b0, v[SAMPLE_WIDTH-1:0]};
  endfunction

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   tap_cnt;
  logic               advance, accept, at_limit, eff_last, first;

  assign in_ready = !valid_out || out_ready;
  assign advance  = in_ready;
  assign accept   = valid_in && in_ready && !reset;
  assign at_limit = (tap_cnt == CNT_W'(TAPS - 1));
  assign eff_last = last_in || at_limit;
  assign first    = (state == IDLE);

  always_comb begin
    state_nxt = state;
    if (accept)
      state_nxt = eff_last ? IDLE : ACCUM;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tap_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        tap_cnt <= eff_last ? '0 : tap_cnt + CNT_W'(1);
    end
  end

  // Stage 1: full-precision product and frame flags
  logic signed [PROD_W-1:0] prod_p1;
  logic                     vld_p1, first_p1, last_p1, err_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
      err_p1   <= 1'b0;
    end else if (advance) begin
      vld_p1 <= accept;
      if (accept) begin
        first_p1 <= first;
        last_p1  <= eff_last;
        err_p1   <= at_limit && !last_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance && accept)
      prod_p1 <= PROD_W'(sample_in) * PROD_W'(coeff_in);
  end

  // Stage 2: accumulate, restarting on the first pair of a frame
  logic signed [ACC_WIDTH-1:0] acc_p2;
  logic                        vld_p2, last_p2, err_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
      err_p2  <= 1'b0;
      acc_p2  <= '0;
    end else if (advance) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        acc_p2  <= (first_p1 ? '0 : acc_p2) + ACC_WIDTH'(prod_p1);
        last_p2 <= last_p1;
        err_p2  <= err_p1;
      end
    end
  end

  // Stage 3: round, shift, saturate into the output holding register
  logic [SAMPLE_WIDTH:0] sat_res;
  logic                  load_out;

  assign sat_res  = saturate(round_shift(acc_p2));
  assign load_out = advance && vld_p2 && last_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      sat_out   <= 1'b0;
      err_out   <= 1'b0;
    end else if (load_out) begin
      valid_out <= 1'b1;
      data_out  <= sat_res[SAMPLE_WIDTH-1:0];
      sat_out   <= sat_res[SAMPLE_WIDTH];
      err_out   <= err_p2;
    end else if (valid_out && out_ready) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_polyphase_mac.sv
// Bench for polyphase_mac: a rounding and a truncating instance share one
// stimulus stream; a frame-level model predicts every delivered result.
module tb_polyphase_mac;

  localparam int SW   = 16;
  localparam int CW   = 16;
  localparam int AW   = 40;
  localparam int TAPS = 31;
  localparam int SH   = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic valid_in = 1'b0, last_in = 1'b0, out_ready = 1'b1;
  logic signed [SW-1:0] sample_in = '0;
  logic signed [CW-1:0] coeff_in  = '0;

  logic in_ready_r, valid_out_r, sat_r, err_r;
  logic in_ready_t, valid_out_t, sat_t, err_t;
  logic signed [SW-1:0] data_r, data_t;

  always #5 clk = ~clk;

  polyphase_mac #(.SAMPLE_WIDTH(SW), .COEFF_WIDTH(CW), .ACC_WIDTH(AW),
                  .TAPS(TAPS), .SHIFT(SH), .ROUND(1)) dut_r (
    .clk(clk), .reset(reset), .valid_in(valid_in), .last_in(last_in),
    .sample_in(sample_in), .coeff_in(coeff_in), .in_ready(in_ready_r),
    .valid_out(valid_out_r), .out_ready(out_ready), .data_out(data_r),
    .sat_out(sat_r), .err_out(err_r));

  polyphase_mac #(.SAMPLE_WIDTH(SW), .COEFF_WIDTH(CW), .ACC_WIDTH(AW),
                  .TAPS(TAPS), .SHIFT(SH), .ROUND(0)) dut_t (
    .clk(clk), .reset(reset), .valid_in(valid_in), .last_in(last_in),
    .sample_in(sample_in), .coeff_in(coeff_in), .in_ready(in_ready_t),
    .valid_out(valid_out_t), .out_ready(out_ready), .data_out(data_t),
    .sat_out(sat_t), .err_out(err_t));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: scale a dot product with floor division
  function automatic void scale(input longint sum, input bit rnd, output longint d, output bit s);
    longint div, num, q;
    div = longint'(1) << SH;
    num = sum + (rnd ? div / 2 : 0);
    q = num / div;
    if ((num % div) != 0 && num < 0) q = q - 1;
    s = 1'b0;
    if (q > 32767) begin q = 32767; s = 1'b1; end
    else if (q < -32768) begin q = -32768; s = 1'b1; end
    d = q;
  endfunction

  typedef struct {
    longint dr; longint dt; bit sr; bit st; bit e;
  } res_t;

  res_t   expq[$];
  longint m_sum = 0;
  int     m_cnt = 0;
  bit     stall_prev = 1'b0;
  longint held_d = 0;

  always @(negedge clk) begin
    if (reset) begin
      expq.delete();
      m_sum = 0;
      m_cnt = 0;
      stall_prev = 1'b0;
    end else begin
      bit m_ready, acc_now, eff, fe;
      res_t r, e;
      m_ready = !valid_out_r || out_ready;
      chk("in_ready_r", in_ready_r, m_ready);
      chk("in_ready_t", in_ready_t, !valid_out_t || out_ready);
      if (stall_prev && valid_out_r) chk("stall_hold", data_r, held_d);
      stall_prev = valid_out_r && !out_ready;
      held_d = data_r;
      if (valid_out_r && out_ready) begin
        chk("result_expected", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("res_valid_t", valid_out_t, 1);
          chk("res_data_r", data_r, e.dr);
          chk("res_data_t", data_t, e.dt);
          chk("res_sat_r", sat_r, e.sr);
          chk("res_sat_t", sat_t, e.st);
          chk("res_err_r", err_r, e.e);
          chk("res_err_t", err_t, e.e);
        end
      end
      acc_now = valid_in && m_ready;
      if (acc_now) begin
        eff = last_in || (m_cnt == TAPS - 1);
        fe  = !last_in && (m_cnt == TAPS - 1);
        m_sum = ((m_cnt == 0) ? 0 : m_sum) + longint'(sample_in) * longint'(coeff_in);
        if (eff) begin
          scale(m_sum, 1'b1, r.dr, r.sr);
          scale(m_sum, 1'b0, r.dt, r.st);
          r.e = fe;
          expq.push_back(r);
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send(input int s, input int c, input bit last);
    bit done = 1'b0;
    valid_in  = 1'b1;
    sample_in = SW'(s);
    coeff_in  = CW'(c);
    last_in   = last;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = in_ready_r;
      @(posedge clk);
      #1;
    end
    chk("send_accepted", done, 1);
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic expect_result(input string name, input longint er, input longint et,
                               input bit es, input bit ee);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = valid_out_r;
    end
    chk({name, "_seen"}, seen, 1);
    chk({name, "_data_r"}, data_r, er);
    chk({name, "_data_t"}, data_t, et);
    chk({name, "_sat"}, sat_r, es);
    chk({name, "_err_r"}, err_r, ee);
    chk({name, "_err_t"}, err_t, ee);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] v;
    case ($urandom_range(0, 3))
      0:       v = ($urandom_range(0, 1) != 0) ? 16'h7fff : 16'h8000;
      1:       v = 16'($urandom_range(0, 7)) - 16'd4;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid_out_r, 0);
    chk("rst_data", data_r, 0);
    chk("rst_sat", sat_r, 0);
    chk("rst_err", err_r, 0);
    chk("rst_in_ready", in_ready_r, 1);
    reset = 1'b0;

    // basic frame and exact latency
    send(1, 32767, 0); send(2, 32767, 0); send(3, 32767, 0); send(4, 32767, 1);
    @(posedge clk); #1;
    chk("lat_early", valid_out_r, 0);
    @(posedge clk); #1;
    chk("lat_valid", valid_out_r, 1);
    chk("basic_data_r", data_r, 10);
    chk("basic_data_t", data_t, 9);
    chk("basic_sat", sat_r, 0);
    chk("basic_err", err_r, 0);
    @(posedge clk); #1;

    // rounding vs truncation on single-pair frames
    send(3, 16384, 1);
    expect_result("rnd_pos", 2, 1, 0, 0);
    send(-3, 16384, 1);
    expect_result("rnd_neg", -1, -2, 0, 0);

    // saturation with a full-length frame
    for (int i = 0; i < TAPS; i++) send(32767, 32767, i == TAPS - 1);
    expect_result("sat_pos", 32767, 32767, 1, 0);
    for (int i = 0; i < TAPS; i++) send(-32768, 32767, i == TAPS - 1);
    expect_result("sat_neg", -32768, -32768, 1, 0);

    // backpressure across two back-to-back frames
    out_ready = 1'b0;
    fork
      begin
        for (int k = 1; k <= 4; k++) send(k, 32767, k == 4);
        for (int k = 1; k <= 4; k++) send(2 * k, 32767, k == 4);
      end
      begin
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
          @(negedge clk);
          seen = valid_out_r;
        end
        chk("bp_seen", seen, 1);
        for (int i = 0; i < 5; i++) begin
          chk("bp_in_ready", in_ready_r, 0);
          chk("bp_hold", data_r, 10);
          @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_first_valid", valid_out_r, 1);
        chk("bp_first_data", data_r, 10);
        @(posedge clk); #1;
      end
    join
    expect_result("bp_second", 20, 19, 0, 0);

    // forced end at TAPS; pair 32 opens a new frame
    for (int i = 0; i < TAPS + 1; i++) send(1, 32767, 0);
    expect_result("forced", 31, 30, 0, 1);
    send(1, 32767, 1);
    expect_result("forced_next", 2, 1, 0, 0);

    // reset mid-frame
    send(5, 100, 0); send(6, 100, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_in_ready", in_ready_r, 1);
    chk("mid_rst_valid", valid_out_r, 0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_rst_quiet", valid_out_r, 0);
    end
    @(posedge clk); #1;
    send(1, 32767, 1);
    expect_result("post_reset", 1, 0, 0, 0);

    // randomized traffic with random backpressure
    for (int i = 0; i < 4000; i++) begin
      valid_in  = ($urandom_range(0, 3) != 0);
      sample_in = pick();
      coeff_in  = pick();
      last_in   = (i < 2000) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = (i == 1500);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    valid_in = 1'b0;
    last_in = 1'b0;
    out_ready = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    chk("drain_empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
